// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the RV32 pipeline.
// It holds the PC and keeps at most one instruction-memory request in flight.
// It drives the IF/ID register that decode consumes. Where no fetched word is
// available, it inserts NOP bubbles.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   stall                  decode hold request; IF/ID holds its contents
//   redirect, redirect_pc  taken branch/jump from EXE; redirect_pc[1:0] ignored
//   im_req, im_addr        one-cycle fetch request and its word address
//   im_valid, im_rdata     response strobe and instruction word
//   IF_pc_out              IF/ID program counter
//   IF_instr_out           IF/ID instruction
//   IF_valid               IF/ID valid flag (0 = bubble)
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | issue request for pc (suppressed when redirect is present)
// WAIT  | request outstanding, waiting for im_valid
// HOLD  | response captured in hold_buf while decode is stalled
// DROP  | outstanding response is stale (redirected), discard it
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_valid,
    input  logic [31:0] im_rdata,
    output logic [31:0] IF_pc_out,
    output logic [31:0] IF_instr_out,
    output logic        IF_valid
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_buf, hold_buf_nxt;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_data;

    assign target = redirect_pc & ~32'h0000_0003;

    // Moore request: only redirect may gate it, so im_req/im_addr have no
    // other combinational dependence on inputs.
    assign im_req  = (state == S_FETCH) && !redirect;
    assign im_addr = pc;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_buf_nxt = hold_buf;
        deliver      = 1'b0;
        deliver_data = hold_buf;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = target;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = im_valid ? S_FETCH : S_DROP;
                end else if (im_valid) begin
                    if (stall) begin
                        hold_buf_nxt = im_rdata;
                        state_nxt    = S_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_data = im_rdata;
                        pc_nxt       = pc + 32'd4;
                        state_nxt    = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_FETCH;
                end else if (!stall) begin
                    deliver   = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                if (redirect) begin
                    pc_nxt = target;
                end
                if (im_valid) begin
                    state_nxt = S_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            hold_buf <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    // The IF/ID update priority is: redirect, then stall, then deliver, then bubble.
    // The pc captured on delivery is the pre-increment fetch address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IF_pc_out    <= 32'd0;
            IF_instr_out <= NOP_INSTR;
            IF_valid     <= 1'b0;
        end else if (redirect) begin
            IF_instr_out <= NOP_INSTR;
            IF_valid     <= 1'b0;
        end else if (stall) begin
            IF_pc_out    <= IF_pc_out;
            IF_instr_out <= IF_instr_out;
            IF_valid     <= IF_valid;
        end else if (deliver) begin
            IF_pc_out    <= pc;
            IF_instr_out <= deliver_data;
            IF_valid     <= 1'b1;
        end else begin
            IF_instr_out <= NOP_INSTR;
            IF_valid     <= 1'b0;
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage RV32 pipeline, directly upstream of the decode stage. Holds the program counter and issues one request at a time to the instruction-memory port. Drives the IF/ID pipeline register (`IF_pc_out`, `IF_instr_out`), which decode consumes. Absorbs decode stalls, EXE branch/jump redirects and variable instruction-memory latency, inserting NOP bubbles where no valid instruction is available.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 1: decode hold request (load-use hazard or downstream memory stall). The IF/ID register must hold.
- `redirect` in 1: EXE resolved a taken branch or jump.
- `redirect_pc` in 32: target address. Bits [1:0] are ignored.
- `im_req` out 1: fetch request, asserted for exactly one cycle per request.
- `im_addr` out 32: fetch address, valid while `im_req`=1.
- `im_valid` in 1: response strobe. Exactly one response per request, arriving at least 1 cycle after `im_req`.
- `im_rdata` in 32: instruction word, valid with `im_valid`.
- `IF_pc_out` out 32: IF/ID PC.
- `IF_instr_out` out 32: IF/ID instruction.
- `IF_valid` out 1: 1 when `IF_instr_out` is a fetched instruction, 0 for a bubble.

## Operation
Internal state:
- `pc` (32 bits, low 2 bits always 0).
- `buf` (32-bit held instruction).
- FSM with states FETCH, WAIT, HOLD, DROP.

Reset (`rst`=0, asynchronous):
- `pc`=`RESET_PC`, state=FETCH.
- `IF_pc_out`=0, `IF_instr_out`=`NOP_INSTR`, `IF_valid`=0, `buf`=0.

FSM transitions:
- FETCH:
  - `im_req` = ~`redirect`, `im_addr`=`pc`.
  - If `redirect`: `pc`←`redirect_pc`&~3, stay in FETCH, no request issued.
  - Otherwise go to WAIT.
- WAIT: `im_req`=0.
  - `redirect`=1 and `im_valid`=1: discard the response, `pc`←target, go to FETCH.
  - `redirect`=1 and `im_valid`=0: `pc`←target, go to DROP.
  - `im_valid`=1 and `stall`=0: deliver `im_rdata`, `pc`←`pc`+4, go to FETCH.
  - `im_valid`=1 and `stall`=1: `buf`←`im_rdata`, go to HOLD.
- HOLD: `im_req`=0.
  - `redirect`: `pc`←target, go to FETCH.
  - `stall`=0: deliver `buf`, `pc`←`pc`+4, go to FETCH.
  - Otherwise stay in HOLD.
- DROP: `im_req`=0. The outstanding response is stale.
  - `im_valid`: discard it, go to FETCH.
  - A further `redirect` overwrites `pc` with the new target and stays in DROP (or goes to FETCH if `im_valid` arrives in the same cycle).

IF/ID register update, evaluated every cycle in priority order:
1. `redirect`=1: load `IF_instr_out`=`NOP_INSTR` and `IF_valid`=0. `IF_pc_out` is unchanged. Redirect wins over `stall`.
2. `stall`=1: hold all three outputs.
3. Deliver: load `IF_pc_out`=`pc`, `IF_instr_out`=data, `IF_valid`=1.
4. No deliver: bubble, i.e. `IF_instr_out`=`NOP_INSTR` and `IF_valid`=0. `IF_pc_out` is unchanged.

Arithmetic and addressing:
- `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Never more than one request is outstanding.

## Timing
- Minimum fetch period is 2 cycles per instruction (FETCH, then WAIT with `im_valid` on the next cycle). Each extra cycle of memory latency adds one cycle.
- Request to IF/ID latency: the IF/ID outputs update on the clock edge that samples `im_valid`. The delivered word is visible in the cycle after `im_valid`.
- Redirect latency: the request for the target is issued in the cycle after `redirect` when the state was FETCH, WAIT with `im_valid`, or HOLD. From DROP, the request is issued in the cycle after the stale `im_valid`.
- `im_req` is a Moore output of FETCH gated only by `redirect`. No other combinational path goes from inputs to `im_req` or `im_addr`.
- Asserting `rst` mid-WAIT abandons the request. The bench memory must also be reset, and no response is consumed after reset release.

## Test plan
- Reset, release with `RESET_PC`=0 and 1-cycle memory returning 32'h0000_0093 at addresses 0, 4 and 8:
  - `im_addr` sequence is 0, 4, 8 on every other cycle.
  - `IF_pc_out` is 0, 4, 8 with `IF_valid`=1.
  - NOP bubbles with `IF_valid`=0 appear between deliveries.
- `stall`=1 for 3 cycles spanning the `im_valid` for address 4:
  - The response is captured in HOLD and IF/ID outputs hold.
  - After release, `IF_pc_out`=4 with the buffered word. The next `im_addr`=8.
- `redirect` with `redirect_pc`=32'h0000_0103 while in WAIT, with a 3-cycle memory:
  - The stale response is dropped and IF/ID shows NOP.
  - The next `im_addr`=32'h0000_0100.
- `redirect` and `stall` asserted together in HOLD:
  - `IF_instr_out`=32'h0000_0013, `IF_valid`=0.
  - The next request targets the redirect address.
- `pc` at 32'hFFFF_FFFC: after delivery, the next `im_addr`=32'h0000_0000.
- `rst` asserted during WAIT: all outputs take reset values immediately, and after release the first `im_addr`=`RESET_PC`.
